spike_rate_decoder: RTL and testbench
=====================================

Name: spike_rate_decoder

Overview:
- Receive-side counterpart of the integrate-and-fire neuron: the neuron turns an 8-bit input current into a spike train, and this block turns a spike train back into an 8-bit rate value.
- It counts spikes over a programmable window of clock cycles.
- At the end of each window it presents the saturated count on a valid/ready output port.
- It sits downstream of neuron `spike` outputs and feeds the monitoring logic or the current input of the next layer.

Parameters:
- WIDTH, 8, width of rate_out and of the spike counter.
- WIN_W, 10, width of window_len and of the internal window counter.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  decoding enable. Rising into 1 starts windows; dropping to 0 aborts the current window.
- spike_in  input  1  spike from the neuron; one spike per cycle at most.
- window_len  input  WIN_W  window length in cycles; sampled at window start.
- rate_out  output  WIDTH  spike count of the last completed window.
- rate_sat  output  1  spike count saturated during that window.
- rate_valid  output  1  rate_out/rate_sat hold an unconsumed result.
- rate_ready  input  1  consumer accepts the result this cycle.
- drop  output  1  one-cycle pulse: a completed result was discarded.
- busy  output  1  a window is in progress (state COUNT).

Behaviour:
- Reset: asynchronous, active-high. While rst=1 all outputs are 0, state is IDLE, and all counters are 0.
- State IDLE:
  - Condition en=1 and window_len!=0: the next edge latches len_q=window_len, clears win_cnt and spk_cnt to 0, and goes to COUNT.
  - window_len=0: stay in IDLE.
- State COUNT, each cycle:
  - spk_cnt increments if spike_in=1, saturating at 2^WIDTH-1.
  - sat_q is set if spike_in=1 while spk_cnt is already at max.
  - win_cnt increments.
- Last cycle of a window (win_cnt==len_q-1):
  - The final count includes that cycle's spike_in.
  - The completed result is spk_final = spk_cnt + spike_in (saturated), with sat_final = sat_q OR (spike_in=1 AND spk_cnt at max).
  - On the same edge, the next window starts immediately with no dead cycle. It re-samples window_len; if window_len=0, go to IDLE instead.
- Result latency: rate_valid rises on the edge that ends the window, i.e. 1 cycle after the last window cycle.
- Output handshake: a transfer occurs when rate_valid=1 and rate_ready=1. Result registers update only on window completion.
- Transfer with no new result the same edge: rate_valid clears.
- New result with rate_valid=0, or with a transfer on the same edge: load rate_out, rate_sat; rate_valid=1; drop=0.
- New result with rate_valid=1 and rate_ready=0: the new result is discarded, the old one is held, drop=1 for one cycle.
- rate_out and rate_sat are stable while rate_valid=1 and no transfer has occurred.
- en=0 in COUNT: the next edge returns to IDLE and discards the partial counts. The result registers and rate_valid are unaffected, and the handshake continues.
- Changes to window_len mid-window are ignored until the next window start.
- window_len=1: every COUNT cycle is a window end, so rate_out is 0 or 1 per cycle.
- busy = (state==COUNT).
- rst asserted mid-window or mid-handshake: all state clears immediately and any pending result is lost.

Test Plan:
- Spikes on alternate cycles:
  - Stimulus: en=1, window_len=10, spike_in alternating 1,0, rate_ready=1.
  - Required: rate_out=5, rate_sat=0, rate_valid pulses once every 10 cycles, busy=1 throughout.
- Saturating window:
  - Stimulus: window_len=300, spike_in=1 constant.
  - Required: rate_out=255, rate_sat=1.
  - Then with window_len=200: rate_out=200, rate_sat=0.
- Back-pressure:
  - Stimulus: window_len=4, spike pattern 1,1,0,1; rate_ready=0 for 2 windows, then 1.
  - Required: rate_out=3 held stable, drop=1 for exactly 1 cycle at the 2nd window end, and that window's result is never presented.
- Simultaneous transfer and completion:
  - Stimulus: rate_ready=1 in the same cycle a window completes.
  - Required: new value loaded, rate_valid stays 1, drop=0.
- Abort mid-window:
  - Stimulus: window_len=8, 3 spikes, en=0 at cycle 5, en=1 later.
  - Required: IDLE, busy=0, no result emitted, the next window counts from 0.
- Asynchronous reset mid-window:
  - Stimulus: rst pulse between clock edges with rate_valid=1.
  - Required: all outputs 0 immediately; window_len=1 afterwards gives per-cycle rate_out equal to spike_in delayed by 1 cycle.

Source files
------------

// File: rtl/spike_rate_if.sv
// Valid/ready result port of the spike rate decoder: the producer presents a
// rate value and its saturation flag, the consumer accepts it with rate_ready.
interface spike_rate_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] rate_out;
    logic             rate_sat;
    logic             rate_valid;
    logic             rate_ready;

    modport master (
        output rate_out,
        output rate_sat,
        output rate_valid,
        input  rate_ready
    );

    modport slave (
        input  rate_out,
        input  rate_sat,
        input  rate_valid,
        output rate_ready
    );
endinterface

// File: rtl/spike_rate_decoder.sv
// Counts spikes over a programmable window of cycles and presents the saturated
// count of each completed window on a valid/ready port; back-to-back windows.
module spike_rate_decoder #(
    parameter int WIDTH = 8,
    parameter int WIN_W = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             spike_in,
    input  logic [WIN_W-1:0] window_len,
    spike_rate_if.master     rate,
    output logic             drop,
    output logic             busy
);
    typedef enum logic {IDLE, COUNT} state_t;

    localparam logic [WIN_W-1:0] WIN_ONE = WIN_W'(1);
    localparam logic [WIDTH-1:0] SPK_ONE = WIDTH'(1);

    state_t           state_q, state_d;
    logic [WIN_W-1:0] len_q, len_d;
    logic [WIN_W-1:0] win_cnt_q, win_cnt_d;
    logic [WIDTH-1:0] spk_cnt_q, spk_cnt_d;
    logic             sat_q, sat_d;
    logic [WIDTH-1:0] rate_out_q, rate_out_d;
    logic             rate_sat_q, rate_sat_d;
    logic             rate_valid_q, rate_valid_d;
    logic             drop_q, drop_d;

    logic             spk_max;
    logic [WIDTH-1:0] spk_inc;
    logic             sat_inc;
    logic             win_end;

    // Count including this cycle's spike; also the completed result at window end.
    assign spk_max = (spk_cnt_q == {WIDTH{1'b1}});
    assign spk_inc = (spike_in && !spk_max) ? spk_cnt_q + SPK_ONE : spk_cnt_q;
    assign sat_inc = sat_q | (spike_in & spk_max);

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        win_cnt_d = win_cnt_q;
        spk_cnt_d = spk_cnt_q;
        sat_d     = sat_q;
        win_end   = 1'b0;
        case (state_q)
            IDLE: begin
                if (en && (window_len != '0)) begin
                    state_d   = COUNT;
                    len_d     = window_len;
                    win_cnt_d = '0;
                    spk_cnt_d = '0;
                    sat_d     = 1'b0;
                end
            end
            COUNT: begin
                if (!en) begin
                    state_d   = IDLE;
                    win_cnt_d = '0;
                    spk_cnt_d = '0;
                    sat_d     = 1'b0;
                end else if (win_cnt_q == len_q - WIN_ONE) begin
                    win_end   = 1'b1;
                    win_cnt_d = '0;
                    spk_cnt_d = '0;
                    sat_d     = 1'b0;
                    // Next window starts on the same edge unless the new length is zero.
                    if (window_len != '0) begin
                        len_d = window_len;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    win_cnt_d = win_cnt_q + WIN_ONE;
                    spk_cnt_d = spk_inc;
                    sat_d     = sat_inc;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rate_out_d   = rate_out_q;
        rate_sat_d   = rate_sat_q;
        rate_valid_d = rate_valid_q;
        drop_d       = 1'b0;
        if (win_end) begin
            // A pending unconsumed result wins; the fresh one is discarded.
            if (!rate_valid_q || rate.rate_ready) begin
                rate_out_d   = spk_inc;
                rate_sat_d   = sat_inc;
                rate_valid_d = 1'b1;
            end else begin
                drop_d = 1'b1;
            end
        end else if (rate_valid_q && rate.rate_ready) begin
            rate_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            len_q        <= '0;
            win_cnt_q    <= '0;
            spk_cnt_q    <= '0;
            sat_q        <= 1'b0;
            rate_out_q   <= '0;
            rate_sat_q   <= 1'b0;
            rate_valid_q <= 1'b0;
            drop_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            win_cnt_q    <= win_cnt_d;
            spk_cnt_q    <= spk_cnt_d;
            sat_q        <= sat_d;
            rate_out_q   <= rate_out_d;
            rate_sat_q   <= rate_sat_d;
            rate_valid_q <= rate_valid_d;
            drop_q       <= drop_d;
        end
    end

    assign rate.rate_out   = rate_out_q;
    assign rate.rate_sat   = rate_sat_q;
    assign rate.rate_valid = rate_valid_q;
    assign drop            = drop_q;
    assign busy            = (state_q == COUNT);

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Directed bench for spike_rate_decoder: windowed counting, saturation,
// back-pressure, abort and asynchronous reset, with hand-computed expectations.
module tb_spike_rate_decoder;
    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       spike_in;
    logic [9:0] window_len;
    logic       drop;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    spike_rate_if #(.WIDTH(8)) rif ();

    spike_rate_decoder #(.WIDTH(8), .WIN_W(10)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .spike_in   (spike_in),
        .window_len (window_len),
        .rate       (rif.master),
        .drop       (drop),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rst && rif.rate_valid && rif.rate_ready)
            $display("xfer t=%0t rate_out=%0d rate_sat=%0d", $time, rif.rate_out, rif.rate_sat);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] p4;
        logic [7:0] p8;

        rst = 1'b1; en = 1'b0; spike_in = 1'b0; window_len = '0; rif.rate_ready = 1'b0;
        #1;
        check("rst_valid", rif.rate_valid, 0);
        check("rst_out",   rif.rate_out, 0);
        check("rst_busy",  busy, 0);
        tick(); tick();
        rst = 1'b0;
        tick();
        check("idle_busy", busy, 0);

        // Alternating spikes, 10-cycle windows, consumer always ready.
        en = 1'b1; window_len = 10'd10; rif.rate_ready = 1'b1;
        tick();
        check("a_busy_start", busy, 1);
        for (int w = 0; w < 3; w++) begin
            for (int i = 0; i < 10; i++) begin
                spike_in = (i % 2 == 0);
                tick();
                check("a_valid", rif.rate_valid, (i == 9));
                check("a_busy", busy, 1);
                if (i == 9) begin
                    check("a_out", rif.rate_out, 5);
                    check("a_sat", rif.rate_sat, 0);
                end
            end
        end
        en = 1'b0; spike_in = 1'b0;
        tick();
        check("a_abort_busy", busy, 0);
        check("a_abort_valid", rif.rate_valid, 0);

        // Saturating 300-cycle window, then a 200-cycle window set mid-window.
        window_len = 10'd300; en = 1'b1; spike_in = 1'b1;
        tick();
        window_len = 10'd200;
        repeat (299) tick();
        check("b_valid_early", rif.rate_valid, 0);
        tick();
        check("b_valid1", rif.rate_valid, 1);
        check("b_out1", rif.rate_out, 255);
        check("b_sat1", rif.rate_sat, 1);
        repeat (199) tick();
        check("b_valid_mid", rif.rate_valid, 0);
        tick();
        check("b_valid2", rif.rate_valid, 1);
        check("b_out2", rif.rate_out, 200);
        check("b_sat2", rif.rate_sat, 0);
        en = 1'b0; spike_in = 1'b0;
        tick();
        check("b_idle_busy", busy, 0);

        // Back-pressure with 4-cycle windows.
        rif.rate_ready = 1'b0; window_len = 10'd4; en = 1'b1;
        tick();
        p4 = 4'b1101;
        for (int i = 0; i < 4; i++) begin spike_in = p4[3-i]; tick(); end
        check("c_valid1", rif.rate_valid, 1);
        check("c_out1", rif.rate_out, 3);
        check("c_drop1", drop, 0);
        p4 = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            spike_in = p4[3-i];
            tick();
            check("c_hold_out", rif.rate_out, 3);
            check("c_hold_valid", rif.rate_valid, 1);
            check("c_drop", drop, (i == 3));
        end
        p4 = 4'b0100;
        for (int i = 0; i < 4; i++) begin
            spike_in = p4[3-i];
            rif.rate_ready = (i == 0);
            tick();
            if (i == 0) begin
                check("c_xfer_valid", rif.rate_valid, 0);
                check("c_drop_clear", drop, 0);
            end
        end
        check("c_valid3", rif.rate_valid, 1);
        check("c_out3", rif.rate_out, 1);
        // Consumer accepts on the very edge the next window completes.
        p4 = 4'b1101;
        for (int i = 0; i < 4; i++) begin
            spike_in = p4[3-i];
            rif.rate_ready = (i == 3);
            tick();
        end
        check("d_valid", rif.rate_valid, 1);
        check("d_out", rif.rate_out, 3);
        check("d_drop", drop, 0);
        spike_in = 1'b0;
        tick();
        check("d_after_valid", rif.rate_valid, 0);
        en = 1'b0;
        tick();
        check("d_idle_busy", busy, 0);

        // Abort after 5 cycles of an 8-cycle window holding 3 spikes.
        rif.rate_ready = 1'b1; window_len = 10'd8; en = 1'b1;
        tick();
        p8 = 8'b11100000;
        for (int i = 0; i < 5; i++) begin
            spike_in = p8[7-i];
            tick();
            check("e_part_valid", rif.rate_valid, 0);
        end
        en = 1'b0; spike_in = 1'b0;
        tick();
        check("e_abort_busy", busy, 0);
        check("e_abort_valid", rif.rate_valid, 0);
        repeat (3) tick();
        check("e_idle_valid", rif.rate_valid, 0);
        en = 1'b1;
        tick();
        p8 = 8'b01000100;
        for (int i = 0; i < 8; i++) begin
            spike_in = p8[7-i];
            tick();
            check("e_valid", rif.rate_valid, (i == 7));
        end
        check("e_out", rif.rate_out, 2);

        // Asynchronous reset between edges while a result is pending.
        rif.rate_ready = 1'b0;
        #3;
        check("f_pre_valid", rif.rate_valid, 1);
        rst = 1'b1;
        #1;
        check("f_rst_valid", rif.rate_valid, 0);
        check("f_rst_out", rif.rate_out, 0);
        check("f_rst_sat", rif.rate_sat, 0);
        check("f_rst_drop", drop, 0);
        check("f_rst_busy", busy, 0);
        #1;
        rst = 1'b0;
        window_len = 10'd1; rif.rate_ready = 1'b1; spike_in = 1'b0;
        tick();
        check("f_busy", busy, 1);
        p8 = 8'b10110010;
        for (int i = 0; i < 8; i++) begin
            spike_in = p8[7-i];
            tick();
            check("f_out", rif.rate_out, p8[7-i]);
            check("f_valid", rif.rate_valid, 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
